pic_ctrl_n: RTL and testbench
=============================

Name: pic_ctrl_n

Overview:
Parametrised successor to the 8-input PIC control logic. Manages N_IRQ interrupt request lines with an interrupt request register (IRR), an in-service register (ISR) and an interrupt mask register (IMR). Resolves priority, drives the CPU interrupt line and runs a two-pulse INTA handshake that ends with a vector. Supports edge/level trigger (LTIM), normal/auto EOI, specific/non-specific EOI, and optional rotating priority. Sits between the IR pins and the data-bus buffer / read-write logic.

Parameters:
N_IRQ, 8, number of request lines; legal range 2..32.
VEC_W, 8, vector width; the vector wraps modulo 2^VEC_W.
ID_W, $clog2(N_IRQ), width of a line index (derived; do not override).

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  asynchronous, active-high reset.
ir  in  N_IRQ  raw request lines, already synchronised.
ltim  in  1  1 = level-triggered, 0 = rising-edge-triggered.
aeoi  in  1  1 = auto-EOI at the end of the INTA sequence.
mask_wr  in  1  one-cycle strobe; loads IMR from mask_data.
mask_data  in  N_IRQ  new IMR value.
eoi_wr  in  1  one-cycle EOI command strobe.
eoi_spec  in  1  1 = specific EOI using eoi_id; 0 = non-specific.
eoi_id  in  ID_W  target line for a specific EOI.
rotate_en  in  1  rotating priority enable (see Optional Feature).
inta  in  1  synchronous one-cycle acknowledge pulse from the CPU.
vec_base  in  VEC_W  vector base.
int_o  out  1  interrupt request to the CPU.
vec_out  out  VEC_W  vector, valid while vec_valid is high.
vec_valid  out  1  one-cycle pulse on the second INTA.
irr, isr, imr  out  N_IRQ  register read-back.

Behaviour:
- Reset values: irr = 0, isr = 0, imr = all ones, int_o = 0, vec_out = 0, vec_valid = 0, priority pointer = 0, FSM = IDLE, edge history = 0. Reset mid-handshake aborts the sequence; no vector is produced.
- IRR, edge mode: bit i sets on the cycle after ir[i] goes 0→1 (registered previous value).
- IRR, level mode: bit i follows ir[i] while not acknowledged.
- IRR clears: bit i clears on ACK1 for the selected line, and in level mode whenever ir[i] = 0.
- Priority order: line 0 is highest, unless rotation is active.
- Candidate: the highest-priority bit of irr & ~imr that has strictly higher priority than the highest-priority ISR bit. pend = a candidate exists.
- FSM states: IDLE, REQ, ACK1.
  - IDLE→REQ when pend; int_o = 1 from the next cycle (registered).
  - REQ→ACK1 on inta. Latch sel = candidate, set isr[sel], clear irr[sel], int_o = 0.
  - Spurious acknowledge: if no candidate exists at the first inta, latch sel = N_IRQ-1, set no ISR bit and flag the cycle as spurious.
  - REQ→IDLE, with int_o dropping, if pend falls before inta arrives (level line removed).
  - ACK1→IDLE on the second inta. vec_out = vec_base + sel (VEC_W bits, modulo wrap) and vec_valid = 1 for exactly one cycle. If aeoi = 1 and the cycle is not spurious, clear isr[sel] in the same cycle.
  - inta pulses in IDLE are ignored; vec_valid stays 0.
- EOI:
  - Non-specific EOI clears the highest-priority set ISR bit, evaluated on the current-cycle ISR.
  - Specific EOI clears isr[eoi_id]; an eoi_id ≥ N_IRQ is ignored.
  - EOI with an empty ISR is a no-op.
- Same-cycle events:
  - EOI and ACK1 together: the EOI acts on the old ISR, then the ACK1 set applies; the newly set bit survives.
  - mask_wr and ACK1 together: the candidate uses the old IMR.
- A masked bit still sets in IRR; it only blocks the request.
- A new request may be raised while ACK1 is pending. int_o re-asserts only after returning to IDLE.

Optional Feature:
Macro PIC_ROTATE_EN.
- Defined: when rotate_en = 1, every EOI (including auto-EOI) sets the priority pointer so the line just cleared becomes lowest priority. Line (cleared+1) mod N_IRQ becomes highest. Candidate and non-specific EOI search start from the pointer.
- Not defined: rotate_en is ignored, the pointer is held at 0 and priority stays fixed.

Test Plan:
1. Reset, then mask_wr with 8'h00; edge ir[3] 0→1 → irr = 8'h08, int_o = 1. With vec_base = 8'h20, two inta → vec_out = 8'h23, vec_valid pulses once, isr = 8'h08, irr = 0.
2. isr = 8'h08; ir[5] edge → int_o stays 0. ir[1] edge → int_o = 1, and acknowledge gives vec 8'h21 and isr = 8'h0A. Non-specific EOI → isr = 8'h08.
3. ltim = 1: raise ir[2], int_o = 1; drop ir[2] before inta → FSM returns to IDLE. inta, inta → vec 8'h27 (spurious), isr unchanged.
4. aeoi = 1, ir[6] edge, imr = 8'hBF → vec 8'h26, isr = 0 after the second inta. Then imr = 8'hFF plus an ir[0] edge → irr = 8'h01, int_o = 0.
5. PIC_ROTATE_EN, rotate_en = 1: service ir[0] and EOI; then raise ir[0] and ir[4] together → line 4 is acknowledged first (vec 8'h24).
6. Assert reset during ACK1 → all outputs return to reset values and no vec_valid appears. With N_IRQ = 16 and vec_base = 8'hF8, ir[12] → vec_out = 8'h04 (wrap).

Source files
------------

// File: rtl/pic_ctrl_n.sv
// pic_ctrl_n: N-line priority interrupt controller with IRR/ISR/IMR and INTA vector handshake.
// Optional rotating priority is compiled in by defining PIC_ROTATE_EN.
module pic_ctrl_n #(
    parameter int N_IRQ = 8,
    parameter int VEC_W = 8,
    localparam int ID_W = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] ir,
    input  logic             ltim,
    input  logic             aeoi,
    input  logic             mask_wr,
    input  logic [N_IRQ-1:0] mask_data,
    input  logic             eoi_wr,
    input  logic             eoi_spec,
    input  logic [ID_W-1:0]  eoi_id,
    input  logic             rotate_en,
    input  logic             inta,
    input  logic [VEC_W-1:0] vec_base,
    output logic             int_o,
    output logic [VEC_W-1:0] vec_out,
    output logic             vec_valid,
    output logic [N_IRQ-1:0] irr,
    output logic [N_IRQ-1:0] isr,
    output logic [N_IRQ-1:0] imr
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK1} state_t;

    localparam logic [ID_W:0]    NONE  = (ID_W+1)'(N_IRQ);
    localparam logic [N_IRQ-1:0] ONE   = N_IRQ'(1);

    // line index that sits k places after pointer p, modulo N_IRQ
    function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] p,
                                               input logic [ID_W:0] k);
        logic [ID_W+1:0] s;
        s = {2'b00, p} + {1'b0, k};
        if (s >= (ID_W+2)'(N_IRQ))
            s = s - (ID_W+2)'(N_IRQ);
        return s[ID_W-1:0];
    endfunction

    // priority rank of the best set bit, NONE when empty
    function automatic logic [ID_W:0] f_rank(input logic [N_IRQ-1:0] v,
                                             input logic [ID_W-1:0] p);
        logic [ID_W:0] r;
        r = NONE;
        for (int k = N_IRQ - 1; k >= 0; k--)
            if (v[f_wrap(p, (ID_W+1)'(k))])
                r = (ID_W+1)'(k);
        return r;
    endfunction

    state_t           r_state, w_state_n;
    logic [N_IRQ-1:0] r_irr, r_isr, r_imr, r_prev;
    logic [ID_W-1:0]  r_ptr, r_sel;
    logic             r_spur, r_int, r_vv;
    logic [VEC_W-1:0] r_vec;

    logic [ID_W:0]    w_req_rank, w_isr_rank;
    logic [ID_W-1:0]  w_cand, w_top, w_ptr_n;
    logic             w_pend, w_ack1, w_ack2;
    logic [N_IRQ-1:0] w_eoi_clr, w_aeoi_clr, w_ack_set, w_irr_n, w_isr_n;

    always_comb begin
        w_req_rank = f_rank(r_irr & ~r_imr, r_ptr);
        w_isr_rank = f_rank(r_isr, r_ptr);
        w_pend     = (w_req_rank < w_isr_rank);
        w_cand     = f_wrap(r_ptr, w_req_rank);
        w_top      = f_wrap(r_ptr, w_isr_rank);
        w_state_n  = r_state;
        w_ack1     = 1'b0;
        w_ack2     = 1'b0;
        unique case (r_state)
            S_IDLE: if (w_pend) w_state_n = S_REQ;
            S_REQ: begin
                if (inta) begin
                    w_state_n = S_ACK1;
                    w_ack1    = 1'b1;
                end else if (!w_pend) begin
                    w_state_n = S_IDLE;
                end
            end
            S_ACK1: begin
                if (inta) begin
                    w_state_n = S_IDLE;
                    w_ack2    = 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        // EOI always acts on the ISR as it stands this cycle
        w_eoi_clr = '0;
        if (eoi_wr) begin
            if (eoi_spec)
                w_eoi_clr = (ONE << eoi_id) & r_isr;
            else if (w_isr_rank != NONE)
                w_eoi_clr = ONE << w_top;
        end
        w_aeoi_clr = (w_ack2 && aeoi && !r_spur) ? (ONE << r_sel) : '0;
        w_ack_set  = (w_ack1 && w_pend) ? (ONE << w_cand) : '0;
        w_isr_n    = (r_isr & ~w_eoi_clr & ~w_aeoi_clr) | w_ack_set;

        if (ltim)
            w_irr_n = ir & ~r_isr & ~w_ack_set;
        else
            w_irr_n = (r_irr & ~w_ack_set) | (ir & ~r_prev);

`ifdef PIC_ROTATE_EN
        w_ptr_n = r_ptr;
        if (rotate_en) begin
            if (w_aeoi_clr != '0)
                w_ptr_n = f_wrap(r_sel, (ID_W+1)'(1));
            else if (w_eoi_clr != '0)
                w_ptr_n = f_wrap(eoi_spec ? eoi_id : w_top, (ID_W+1)'(1));
        end
`else
        w_ptr_n = '0;
`endif
    end

`ifndef PIC_ROTATE_EN
    logic w_unused_rot;
    assign w_unused_rot = rotate_en;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_irr   <= '0;
            r_isr   <= '0;
            r_imr   <= '1;
            r_prev  <= '0;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_spur  <= 1'b0;
            r_int   <= 1'b0;
            r_vv    <= 1'b0;
            r_vec   <= '0;
        end else begin
            r_state <= w_state_n;
            r_irr   <= w_irr_n;
            r_isr   <= w_isr_n;
            r_prev  <= ir;
            r_ptr   <= w_ptr_n;
            r_int   <= (w_state_n == S_REQ);
            r_vv    <= w_ack2;
            if (mask_wr)
                r_imr <= mask_data;
            if (w_ack1) begin
                r_sel  <= w_pend ? w_cand : ID_W'(N_IRQ - 1);
                r_spur <= !w_pend;
            end
            if (w_ack2)
                r_vec <= vec_base + VEC_W'(r_sel);
        end
    end

    assign int_o     = r_int;
    assign vec_out   = r_vec;
    assign vec_valid = r_vv;
    assign irr       = r_irr;
    assign isr       = r_isr;
    assign imr       = r_imr;
endmodule

// File: tb/tb_pic_ctrl_n.sv
// tb_pic_ctrl_n: directed scenarios plus random traffic against a rank-based reference model.
// Builds with or without PIC_ROTATE_EN; the model follows the same switch.
`timescale 1ns/1ps
module tb_pic_ctrl_n;
    localparam int N = 8;
`ifdef PIC_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ir = '0, mask_data = '0, vec_base = 8'h20;
    logic       ltim = 0, aeoi = 0, mask_wr = 0, eoi_wr = 0;
    logic       eoi_spec = 0, rotate_en = 0, inta = 0;
    logic [2:0] eoi_id = '0;
    logic       int_o, vec_valid;
    logic [7:0] vec_out, irr, isr, imr;

    logic [15:0] ir16 = '0, mask16 = '0;
    logic        mask_wr16 = 0, inta16 = 0;
    logic        int16, vv16;
    logic [7:0]  vec16;
    logic [15:0] irr16, isr16, imr16;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    pic_ctrl_n #(.N_IRQ(8), .VEC_W(8)) u_dut (
        .clk(clk), .reset(reset), .ir(ir), .ltim(ltim), .aeoi(aeoi),
        .mask_wr(mask_wr), .mask_data(mask_data), .eoi_wr(eoi_wr),
        .eoi_spec(eoi_spec), .eoi_id(eoi_id), .rotate_en(rotate_en),
        .inta(inta), .vec_base(vec_base), .int_o(int_o), .vec_out(vec_out),
        .vec_valid(vec_valid), .irr(irr), .isr(isr), .imr(imr)
    );

    pic_ctrl_n #(.N_IRQ(16), .VEC_W(8)) u_d16 (
        .clk(clk), .reset(reset), .ir(ir16), .ltim(1'b0), .aeoi(1'b0),
        .mask_wr(mask_wr16), .mask_data(mask16), .eoi_wr(1'b0),
        .eoi_spec(1'b0), .eoi_id(4'd0), .rotate_en(1'b0),
        .inta(inta16), .vec_base(8'hF8), .int_o(int16), .vec_out(vec16),
        .vec_valid(vv16), .irr(irr16), .isr(isr16), .imr(imr16)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference model: phase 0 = no request, 1 = int raised, 2 = first ack taken
    logic [7:0] m_irr, m_isr, m_imr, m_prev, m_vec;
    logic       m_int, m_vv, m_spur;
    int         m_phase, m_ptr, m_sel;

    function automatic int prio_rank(int line, int ptr);
        return (line - ptr + N) % N;
    endfunction

    function automatic int best(logic [7:0] v, int ptr);
        int b = -1;
        for (int i = 0; i < N; i++)
            if (v[i] && (b < 0 || prio_rank(i, ptr) < prio_rank(b, ptr)))
                b = i;
        return b;
    endfunction

    task automatic model_reset();
        m_irr = '0; m_isr = '0; m_imr = '1; m_prev = '0; m_vec = '0;
        m_int = 0; m_vv = 0; m_spur = 0;
        m_phase = 0; m_ptr = 0; m_sel = 0;
    endtask

    task automatic model_update();
        int c, t, clr, nptr;
        logic pend, ack1, ack2, rot;
        logic [7:0] nirr, nisr;
        rot  = ROT && rotate_en;
        c    = best(m_irr & ~m_imr, m_ptr);
        t    = best(m_isr, m_ptr);
        pend = (c >= 0) && (t < 0 || prio_rank(c, m_ptr) < prio_rank(t, m_ptr));
        ack1 = (m_phase == 1) && inta;
        ack2 = (m_phase == 2) && inta;
        nirr = m_irr; nisr = m_isr; nptr = m_ptr;
        if (eoi_wr) begin
            clr = eoi_spec ? int'(eoi_id) : t;
            if (clr >= 0 && clr < N && m_isr[clr]) begin
                nisr[clr] = 1'b0;
                if (rot) nptr = (clr + 1) % N;
            end
        end
        m_vv = ack2;
        if (ack2) begin
            m_vec = 8'(int'(vec_base) + m_sel);
            if (aeoi && !m_spur) begin
                nisr[m_sel] = 1'b0;
                if (rot) nptr = (m_sel + 1) % N;
            end
        end
        if (ack1) begin
            m_spur = !pend;
            m_sel  = pend ? c : N - 1;
            if (pend) begin
                nisr[c] = 1'b1;
                nirr[c] = 1'b0;
            end
        end
        if (ltim) begin
            for (int i = 0; i < N; i++)
                nirr[i] = ir[i] && !m_isr[i] && !(ack1 && pend && i == c);
        end else begin
            nirr = nirr | (ir & ~m_prev);
        end
        case (m_phase)
            0: m_phase = pend ? 1 : 0;
            1: m_phase = inta ? 2 : (pend ? 1 : 0);
            default: m_phase = inta ? 0 : 2;
        endcase
        m_int = (m_phase == 1);
        if (mask_wr) m_imr = mask_data;
        m_prev = ir; m_irr = nirr; m_isr = nisr; m_ptr = nptr;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("irr", irr, m_irr);
        chk("isr", isr, m_isr);
        chk("imr", imr, m_imr);
        chk("int_o", int_o, m_int);
        chk("vec_valid", vec_valid, m_vv);
        if (m_vv) chk("vec_out", vec_out, m_vec);
        mask_wr = 0; eoi_wr = 0; inta = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rst_irr", irr, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_imr", imr, 8'hFF);
        chk("rst_int", int_o, 1'b0);
        chk("rst_vec", vec_out, 8'h00);
        chk("rst_vv", vec_valid, 1'b0);
    endtask

    task automatic ack();
        inta = 1'b1;
        step();
    endtask

    initial begin
        // basic edge request and vector
        do_reset();
        mask_wr = 1; mask_data = 8'h00; step();
        ir = 8'h08; step();
        chk("t1_irr", irr, 8'h08);
        step();
        chk("t1_int", int_o, 1'b1);
        ack();
        chk("t1_isr", isr, 8'h08);
        chk("t1_irr_clr", irr, 8'h00);
        ack();
        chk("t1_vv", vec_valid, 1'b1);
        chk("t1_vec", vec_out, 8'h23);
        step();
        chk("t1_vv_once", vec_valid, 1'b0);

        // nesting below / above the in-service line
        ir = 8'h28; step(); step();
        chk("t2_low_blocked", int_o, 1'b0);
        ir = 8'h2A; step(); step();
        chk("t2_int", int_o, 1'b1);
        ack(); ack();
        chk("t2_vec", vec_out, 8'h21);
        chk("t2_isr", isr, 8'h0A);
        eoi_wr = 1; eoi_spec = 0; step();
        chk("t2_nseoi", isr, 8'h08);

        // level mode: removed request, then spurious acknowledge
        ir = 8'h00; ltim = 1;
        do_reset();
        mask_wr = 1; mask_data = 8'h00; step();
        ir = 8'h04; step();
        chk("t3_irr", irr, 8'h04);
        step();
        chk("t3_int", int_o, 1'b1);
        ir = 8'h00; step(); step();
        chk("t3_drop", int_o, 1'b0);
        ir = 8'h04; step(); step();
        ir = 8'h00; step();
        ack(); ack();
        chk("t3_spur_vv", vec_valid, 1'b1);
        chk("t3_spur_vec", vec_out, 8'h27);
        chk("t3_spur_isr", isr, 8'h00);

        // auto-EOI, then a masked request
        ltim = 0; ir = 8'h00; aeoi = 1;
        do_reset();
        mask_wr = 1; mask_data = 8'hBF; step();
        ir = 8'h40; step(); step();
        chk("t4_int", int_o, 1'b1);
        ack(); ack();
        chk("t4_vec", vec_out, 8'h26);
        chk("t4_isr", isr, 8'h00);
        mask_wr = 1; mask_data = 8'hFF; ir = 8'h41; step(); step();
        chk("t4_masked_irr", irr, 8'h01);
        chk("t4_masked_int", int_o, 1'b0);
        aeoi = 0;

        // rotating priority
        ir = 8'h00; rotate_en = 1;
        do_reset();
        mask_wr = 1; mask_data = 8'h00; step();
        ir = 8'h01; step(); step();
        ack(); ack();
        chk("t5_vec0", vec_out, 8'h20);
        eoi_wr = 1; eoi_spec = 0; step();
        ir = 8'h00; step();
        ir = 8'h11; step(); step();
        chk("t5_int", int_o, 1'b1);
        ack(); ack();
        chk("t5_vec", vec_out, ROT ? 8'h24 : 8'h20);
        rotate_en = 0;

        // reset in the middle of the handshake
        ir = 8'h00;
        do_reset();
        mask_wr = 1; mask_data = 8'h00; step();
        ir = 8'h08; step(); step();
        ack();
        chk("t6_ack1_isr", isr, 8'h08);
        ir = 8'h00;
        reset = 1'b1;
        #1;
        chk("t6_async_isr", isr, 8'h00);
        chk("t6_async_imr", imr, 8'hFF);
        chk("t6_async_int", int_o, 1'b0);
        do_reset();
        ack(); ack();
        chk("t6_no_vec", vec_valid, 1'b0);

        // 16-line instance: vector wraps past 8'hFF
        mask_wr16 = 1; mask16 = '0; step();
        mask_wr16 = 0; ir16 = 16'h1000; step(); step();
        chk("t6_16_int", int16, 1'b1);
        inta16 = 1; step(); inta16 = 0;
        chk("t6_16_isr", isr16, 16'h1000);
        inta16 = 1; step(); inta16 = 0;
        chk("t6_16_vv", vv16, 1'b1);
        chk("t6_16_vec", vec16, 8'h04);

        // random traffic
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 0) begin
                ltim      = 1'($urandom_range(0, 1));
                aeoi      = 1'($urandom_range(0, 1));
                rotate_en = 1'($urandom_range(0, 1));
                vec_base  = 8'($urandom);
            end
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) ir[i] = ~ir[i];
            mask_wr   = ($urandom_range(0, 19) == 0);
            mask_data = 8'($urandom & $urandom);
            eoi_wr    = ($urandom_range(0, 5) == 0);
            eoi_spec  = 1'($urandom_range(0, 1));
            eoi_id    = 3'($urandom_range(0, 7));
            inta      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 999) == 0) begin
                mask_wr = 0; eoi_wr = 0; inta = 0;
                do_reset();
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
